fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 131 +++++++++++++
 tb/tb_fetch_queue.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// Show-ahead circular queue of fetched instruction pairs sitting between fetch and decode.
// Invalid slots are masked to NOP with the prediction flag cleared; a pair with no valid slot is never stored.
module fetch_queue #(
  parameter int          DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [31:0]              pc_i,
  input  logic [31:0]              inst0_i,
  input  logic [31:0]              inst1_i,
  input  logic                     valid0_i,
  input  logic                     valid1_i,
  input  logic                     pred_taken_0_i,
  input  logic                     pred_taken_1_i,
  output logic                     full_o,
  input  logic                     stall_i,
  output logic                     pair_valid_o,
  output logic [31:0]              pc_o,
  output logic [31:0]              inst0_o,
  output logic [31:0]              inst1_o,
  output logic                     pred_taken_0_o,
  output logic                     pred_taken_1_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst0;
    logic [31:0] inst1;
    logic        valid0;
    logic        valid1;
    logic        pt0;
    logic        pt1;
  } entry_t;

  entry_t             mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic   full;
  logic   not_empty;
  logic   push_ok;
  logic   pop_ok;
  entry_t wr_entry;
  entry_t head;

  // Fullness looks only at registered occupancy, so a same-cycle pop never frees a slot for a push.
  assign full      = (count_q == CNT_W'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push_ok   = push_i && !full && (valid0_i || valid1_i) && !flush_i;
  assign pop_ok    = not_empty && !stall_i && !flush_i;

  assign wr_entry = '{
    pc:     pc_i,
    inst0:  inst0_i,
    inst1:  inst1_i,
    valid0: valid0_i,
    valid1: valid1_i,
    pt0:    pred_taken_0_i,
    pt1:    pred_taken_1_i
  };

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_entry;
  end

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    pc_o           = '0;
    inst0_o        = NOP;
    inst1_o        = NOP;
    pred_taken_0_o = 1'b0;
    pred_taken_1_o = 1'b0;
    if (not_empty) begin
      pc_o = head.pc;
      if (head.valid0) begin
        inst0_o        = head.inst0;
        pred_taken_0_o = head.pt0;
      end
      if (head.valid1) begin
        inst1_o        = head.inst1;
        pred_taken_1_o = head.pt1;
      end
    end
  end

  assign full_o       = full;
  assign pair_valid_o = not_empty;
  assign count_o      = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed and randomized bench for fetch_queue, checked against a queue-based reference model.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        flush_i, push_i, stall_i;
  logic [31:0] pc_i, inst0_i, inst1_i;
  logic        valid0_i, valid1_i, pred_taken_0_i, pred_taken_1_i;
  logic        full_o, pair_valid_o, pred_taken_0_o, pred_taken_1_o;
  logic [31:0] pc_o, inst0_o, inst1_o;
  logic [2:0]  count_o;

  fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .push_i(push_i),
    .pc_i(pc_i), .inst0_i(inst0_i), .inst1_i(inst1_i),
    .valid0_i(valid0_i), .valid1_i(valid1_i),
    .pred_taken_0_i(pred_taken_0_i), .pred_taken_1_i(pred_taken_1_i),
    .full_o(full_o), .stall_i(stall_i), .pair_valid_o(pair_valid_o),
    .pc_o(pc_o), .inst0_o(inst0_o), .inst1_o(inst1_o),
    .pred_taken_0_o(pred_taken_0_o), .pred_taken_1_o(pred_taken_1_o),
    .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] pc, i0, i1;
    logic        v0, v1, p0, p1;
  } ent_t;

  ent_t mq[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    ent_t        h;
    logic [31:0] e_pc = 32'h0, e_i0 = NOP, e_i1 = NOP;
    logic        e_p0 = 1'b0, e_p1 = 1'b0;
    if (mq.size() != 0) begin
      h    = mq[0];
      e_pc = h.pc;
      if (h.v0) begin e_i0 = h.i0; e_p0 = h.p0; end
      if (h.v1) begin e_i1 = h.i1; e_p1 = h.p1; end
    end
    chk({tag, ".count"}, 32'(count_o),      32'(mq.size()));
    chk({tag, ".full"},  32'(full_o),       32'(mq.size() == DEPTH));
    chk({tag, ".valid"}, 32'(pair_valid_o), 32'(mq.size() != 0));
    chk({tag, ".pc"},    pc_o,    e_pc);
    chk({tag, ".inst0"}, inst0_o, e_i0);
    chk({tag, ".inst1"}, inst1_o, e_i1);
    chk({tag, ".pt0"},   32'(pred_taken_0_o), 32'(e_p0));
    chk({tag, ".pt1"},   32'(pred_taken_1_o), 32'(e_p1));
  endtask

  // One clock: capture the offered inputs, let the edge happen, apply the queue rules to the model.
  task automatic step(input string tag);
    ent_t e;
    bit   was_full, do_pop, do_push;
    e        = '{pc_i, inst0_i, inst1_i, valid0_i, valid1_i, pred_taken_0_i, pred_taken_1_i};
    was_full = (mq.size() == DEPTH);
    do_pop   = (mq.size() != 0) && !stall_i;
    do_push  = push_i && !was_full && (valid0_i || valid1_i);
    @(posedge clk_i);
    if (flush_i) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
    check_all(tag);
  endtask

  task automatic offer(input logic [31:0] pc, input logic [31:0] i0, input logic [31:0] i1,
                       input logic v0, input logic v1, input logic p0, input logic p1);
    push_i = 1'b1; pc_i = pc; inst0_i = i0; inst1_i = i1;
    valid0_i = v0; valid1_i = v1; pred_taken_0_i = p0; pred_taken_1_i = p1;
  endtask

  task automatic idle();
    push_i = 1'b0; flush_i = 1'b0; pc_i = '0; inst0_i = '0; inst1_i = '0;
    valid0_i = 1'b0; valid1_i = 1'b0; pred_taken_0_i = 1'b0; pred_taken_1_i = 1'b0;
  endtask

  initial begin
    rst_n_i = 1'b0;
    stall_i = 1'b0;
    idle();
    #12;
    check_all("reset");
    offer(32'h40, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b1);
    @(posedge clk_i); #1;
    check_all("reset_clocked");

    // Release between edges; the very next edge must accept the push.
    @(negedge clk_i);
    rst_n_i = 1'b1;
    offer(32'h100, 32'h00500093, 32'h00A00113, 1'b1, 1'b1, 1'b0, 1'b0);
    step("first_push");
    chk("first_pc", pc_o, 32'h100);
    chk("first_i0", inst0_o, 32'h00500093);
    chk("first_i1", inst1_o, 32'h00A00113);
    idle();
    step("first_pop");
    chk("drained_valid", 32'(pair_valid_o), 32'd0);
    chk("drained_i0", inst0_o, 32'h00000013);

    // Fill under stall; fifth push bounces off full.
    stall_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      offer(32'h100 + 32'(8 * k), 32'hA000 + 32'(k), 32'hB000 + 32'(k), 1'b1, 1'b1, k[0], ~k[0]);
      step("fill");
      if (k == 3) chk("full_after_4", 32'(full_o), 32'd1);
    end
    chk("count_after_5", 32'(count_o), 32'd4);
    idle();
    stall_i = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("pop_order", pc_o, 32'h100 + 32'(8 * k));
      step("drain");
    end

    // Full with pop and push in the same cycle: push rejected, then accepted next cycle.
    stall_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      offer(32'h180 + 32'(8 * k), 32'($urandom), 32'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      step("refill");
    end
    stall_i = 1'b0;
    offer(32'h300, 32'h33, 32'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    step("full_pop_push");
    chk("count_4_to_3", 32'(count_o), 32'd3);
    step("push_after_full");
    chk("count_steady", 32'(count_o), 32'd3);

    // Slot masking and dropped empty pairs.
    idle();
    flush_i = 1'b1;
    step("flush_empty");
    flush_i = 1'b0;
    stall_i = 1'b1;
    offer(32'h400, 32'h0000_1111, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 1'b1);
    step("mask_slot1");
    chk("mask_i1", inst1_o, 32'h00000013);
    chk("mask_pt1", 32'(pred_taken_1_o), 32'd0);
    offer(32'h408, 32'hCAFEF00D, 32'h2222, 1'b0, 1'b1, 1'b1, 1'b1);
    step("mask_slot0");
    offer(32'h410, 32'h5555, 32'h6666, 1'b0, 1'b0, 1'b1, 1'b1);
    step("drop_empty_pair");
    chk("drop_count", 32'(count_o), 32'd2);
    stall_i = 1'b0;
    idle();
    step("pop_masked0");
    step("pop_masked1");

    // Flush wins over a simultaneous push.
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      offer(32'h500 + 32'(8 * k), 32'($urandom), 32'($urandom), 1'b1, 1'b1, 1'b0, 1'b0);
      step("pre_flush");
    end
    offer(32'h600, 32'h77, 32'h88, 1'b1, 1'b1, 1'b0, 1'b0);
    flush_i = 1'b1;
    step("flush_push");
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(pair_valid_o), 32'd0);
    flush_i = 1'b0;
    offer(32'h200, 32'h99, 32'hAA, 1'b1, 1'b1, 1'b1, 1'b0);
    step("post_flush_push");
    chk("post_flush_pc", pc_o, 32'h200);

    // Steady state at occupancy 2: push and pop every cycle so both pointers wrap repeatedly.
    offer(32'h208, 32'hBB, 32'hCC, 1'b1, 1'b1, 1'b0, 1'b0);
    step("steady_fill");
    stall_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      offer(32'h700 + 32'(8 * k), 32'($urandom), 32'($urandom), 1'b1, 1'b1, 1'($urandom), 1'($urandom));
      step("steady");
    end
    chk("steady_count", 32'(count_o), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      push_i         = ($urandom_range(0, 3) != 0);
      stall_i        = ($urandom_range(0, 2) == 0);
      flush_i        = ($urandom_range(0, 39) == 0);
      pc_i           = 32'($urandom);
      inst0_i        = 32'($urandom);
      inst1_i        = 32'($urandom);
      valid0_i       = ($urandom_range(0, 5) != 0);
      valid1_i       = ($urandom_range(0, 5) != 0);
      pred_taken_0_i = 1'($urandom);
      pred_taken_1_i = 1'($urandom);
      step("random");
    end

    // Asynchronous reset mid-operation, between edges.
    idle();
    stall_i = 1'b1;
    offer(32'h800, 32'h1, 32'h2, 1'b1, 1'b1, 1'b1, 1'b1);
    step("pre_async");
    step("pre_async2");
    #2;
    rst_n_i = 1'b0;
    #1;
    mq.delete();
    check_all("async_reset");
    @(negedge clk_i);
    rst_n_i = 1'b1;
    stall_i = 1'b0;
    offer(32'h900, 32'h3, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1);
    step("after_async");
    chk("after_async_pc", pc_o, 32'h900);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
